// File: rtl/mem_wb_stage.sv
// Elastic MEM->WB pipeline stage with an optional 2-entry skid buffer.
// It also suppresses writes to x0, selects the writeback result and counts retired instructions.
module mem_wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       ReadDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       ALUResultW,
  output logic [XLEN-1:0]       ReadDataW,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [XLEN-1:0]       ResultW,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      retired_count
);

  typedef struct packed {
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       rdata;
    logic [XLEN-1:0]       pc4;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic [1:0]            src;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q;
  entry_t           head_q;
  entry_t           skid_q;
  entry_t           in_entry;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire;
  logic             out_fire;

  always_comb begin
    in_entry.alu      = ALUResultM;
    in_entry.rdata    = ReadDataM;
    in_entry.pc4      = PCPlus4M;
    in_entry.rd       = RdM;
    in_entry.regwrite = RegWriteM;
    in_entry.src      = ResultSrcM;
  end

  assign out_valid = (state_q != StEmpty);
  // With the skid entry, readiness comes from registered state only, never from out_ready.
  assign in_ready  = (SKID != 0) ? (state_q != StTwo) : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (out_fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        state_q <= StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (in_fire) begin
              state_q <= StOne;
              head_q  <= in_entry;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              head_q <= in_entry;
            end else if (in_fire && (SKID != 0)) begin
              state_q <= StTwo;
              skid_q  <= in_entry;
            end else if (out_fire) begin
              state_q <= StEmpty;
            end
          end
          StTwo: begin
            if (out_fire) begin
              state_q <= StOne;
              head_q  <= skid_q;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign ALUResultW    = head_q.alu;
  assign ReadDataW     = head_q.rdata;
  assign PCPlus4W      = head_q.pc4;
  assign RdW           = head_q.rd;
  assign ResultSrcW    = head_q.src;
  assign RegWriteW     = out_valid && head_q.regwrite && (head_q.rd != '0);
  assign occupancy     = state_q;
  assign retired_count = cnt_q;

  always_comb begin
    unique case (head_q.src)
      2'b01:   ResultW = head_q.rdata;
      2'b10:   ResultW = head_q.pc4;
      default: ResultW = head_q.alu;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a SKID=1 instance for the main scenarios and a
// SKID=0, CNT_W=4 instance for combinational readiness and counter wrap.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [1:0]  occupancy;
  logic [31:0] retired_count;

  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, RegWriteW0;
  logic [31:0] ALUResultW0, ReadDataW0, PCPlus4W0, ResultW0;
  logic [4:0]  RdW0;
  logic [1:0]  ResultSrcW0, occupancy0;
  logic [3:0]  retired_count0;

  int n_checks;
  int n_fail;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .SKID(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ResultW(ResultW), .occupancy(occupancy), .retired_count(retired_count)
  );

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .out_valid(out_valid0),
    .out_ready(out_ready0), .ALUResultW(ALUResultW0), .ReadDataW(ReadDataW0),
    .PCPlus4W(PCPlus4W0), .RdW(RdW0), .RegWriteW(RegWriteW0), .ResultSrcW(ResultSrcW0),
    .ResultW(ResultW0), .occupancy(occupancy0), .retired_count(retired_count0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_in(input logic [31:0] alu, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] pc4,
                          input logic [1:0] src, input logic we);
    ALUResultM = alu;
    RdM        = rd;
    ReadDataM  = rdata;
    PCPlus4M   = pc4;
    ResultSrcM = src;
    RegWriteM  = we;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    drive_in(32'h0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
    n_checks++;
    if (ResultW !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", ResultW); end
    n_checks++;
    if (retired_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    n_checks++;
    if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %0h want 0", RegWriteW); end
    n_checks++;
    if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready0: got %0h want 1", in_ready0); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_in(32'h10, 5'd1, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || ResultW !== 32'h10 || RdW !== 5'd1) begin
      n_fail++; $display("FAIL stream_0: got v=%0h res=%h rd=%0d want v=1 res=10 rd=1", out_valid, ResultW, RdW);
    end
    n_checks++;
    if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL stream_we: got %0h want 1", RegWriteW); end
    drive_in(32'h20, 5'd2, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ResultW !== 32'h20 || RdW !== 5'd2 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL stream_1: got res=%h rd=%0d occ=%0d want res=20 rd=2 occ=1", ResultW, RdW, occupancy);
    end
    drive_in(32'h30, 5'd3, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ResultW !== 32'h30 || RdW !== 5'd3 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL stream_2: got res=%h rd=%0d occ=%0d want res=30 rd=3 occ=1", ResultW, RdW, occupancy);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0h want 0", out_valid); end
    n_checks++;
    if (retired_count !== 32'd3) begin n_fail++; $display("FAIL stream_count: got %0d want 3", retired_count); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_in(32'hAAAA, 5'd4, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_one: got occ=%0d rdy=%0h want occ=1 rdy=1", occupancy, in_ready);
    end
    drive_in(32'hBBBB, 5'd5, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got occ=%0d rdy=%0h want occ=2 rdy=0", occupancy, in_ready);
    end
    n_checks++;
    if (ResultW !== 32'hAAAA || RdW !== 5'd4) begin
      n_fail++; $display("FAIL bp_head: got res=%h rd=%0d want res=aaaa rd=4", ResultW, RdW);
    end
    @(negedge clk);
    n_checks++;
    if (occupancy !== 2'd2 || ALUResultW !== 32'hAAAA) begin
      n_fail++; $display("FAIL bp_hold: got occ=%0d alu=%h want occ=2 alu=aaaa", occupancy, ALUResultW);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ResultW !== 32'hBBBB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_retire: got res=%h occ=%0d rdy=%0h want res=bbbb occ=1 rdy=1", ResultW, occupancy, in_ready);
    end
    n_checks++;
    if (retired_count !== 32'd4) begin n_fail++; $display("FAIL bp_count4: got %0d want 4", retired_count); end
    @(negedge clk);
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || retired_count !== 32'd5) begin
      n_fail++; $display("FAIL bp_drain: got occ=%0d v=%0h cnt=%0d want occ=0 v=0 cnt=5", occupancy, out_valid, retired_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_in(32'h1111, 5'd6, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    drive_in(32'h2222, 5'd7, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre: got occ=%0d want 2", occupancy); end
    flush = 1'b1;
    drive_in(32'hCCCC, 5'd8, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || RegWriteW !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty: got occ=%0d v=%0h we=%0h want 0 0 0", occupancy, out_valid, RegWriteW);
    end
    n_checks++;
    if (retired_count !== 32'd5) begin n_fail++; $display("FAIL flush_count: got %0d want 5", retired_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || retired_count !== 32'd5) begin
        n_fail++; $display("FAIL flush_no_ghost: got v=%0h cnt=%0d want v=0 cnt=5", out_valid, retired_count);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_x0_mux;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_in(32'h55, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || RegWriteW !== 1'b0 || ResultW !== 32'h55) begin
      n_fail++; $display("FAIL x0_suppress: got v=%0h we=%0h res=%h want v=1 we=0 res=55", out_valid, RegWriteW, ResultW);
    end
    out_ready = 1'b1;
    drive_in(32'h99, 5'd5, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ResultW !== 32'hDEADBEEF || ResultSrcW !== 2'b01 || RegWriteW !== 1'b1) begin
      n_fail++; $display("FAIL mux_load: got res=%h src=%0d we=%0h want res=deadbeef src=1 we=1", ResultW, ResultSrcW, RegWriteW);
    end
    drive_in(32'h99, 5'd6, 32'h0, 32'h104, 2'b10, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ResultW !== 32'h104 || PCPlus4W !== 32'h104) begin
      n_fail++; $display("FAIL mux_pc4: got res=%h pc4=%h want 104", ResultW, PCPlus4W);
    end
    drive_in(32'h77, 5'd7, 32'h12, 32'h34, 2'b11, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ResultW !== 32'h77 || RegWriteW !== 1'b0) begin
      n_fail++; $display("FAIL mux_src3: got res=%h we=%0h want res=77 we=0", ResultW, RegWriteW);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || retired_count !== 32'd9) begin
      n_fail++; $display("FAIL mux_count: got v=%0h cnt=%0d want v=0 cnt=9", out_valid, retired_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_in(32'h1234, 5'd9, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    drive_in(32'h5678, 5'd10, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL areset_pre: got occ=%0d want 2", occupancy); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || RegWriteW !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_ctrl: got v=%0h occ=%0d we=%0h rdy=%0h want 0 0 0 1", out_valid, occupancy, RegWriteW, in_ready);
    end
    n_checks++;
    if (ResultW !== 32'h0 || ALUResultW !== 32'h0 || RdW !== 5'd0 || retired_count !== 32'h0) begin
      n_fail++; $display("FAIL areset_data: got res=%h alu=%h rd=%0d cnt=%0d want all 0", ResultW, ALUResultW, RdW, retired_count);
    end
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_in(32'hABCD, 5'd3, 32'h0, 32'h0, 2'b00, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || ResultW !== 32'hABCD) begin
      n_fail++; $display("FAIL areset_after: got v=%0h res=%h want v=1 res=abcd", out_valid, ResultW);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || retired_count !== 32'd1) begin
      n_fail++; $display("FAIL areset_retire: got v=%0h cnt=%0d want v=0 cnt=1", out_valid, retired_count);
    end
    out_ready = 1'b0;
  endtask

  // Expected valid/readiness of the single-entry instance tracked cycle by cycle.
  task automatic test_skid0_wrap;
    logic exp_v;
    logic exp_rdy;
    int   acc;
    int   ret;
    exp_v = 1'b0;
    acc   = 0;
    ret   = 0;
    out_ready0 = 1'b0;
    drive_in(32'h42, 5'd1, 32'h0, 32'h0, 2'b00, 1'b1);
    for (int cyc = 0; cyc < 200 && ret < 17; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid0 !== exp_v || occupancy0 !== {1'b0, exp_v}) begin
        n_fail++; $display("FAIL skid0_valid: cycle %0d got v=%0h occ=%0d want v=%0h", cyc, out_valid0, occupancy0, exp_v);
      end
      out_ready0 = ~out_ready0;
      in_valid0  = (acc < 17);
      #1;
      exp_rdy = !exp_v || out_ready0;
      n_checks++;
      if (in_ready0 !== exp_rdy) begin
        n_fail++; $display("FAIL skid0_in_ready: cycle %0d got %0h want %0h", cyc, in_ready0, exp_rdy);
      end
      if (exp_v && out_ready0) ret++;
      if (in_valid0 && exp_rdy) acc++;
      exp_v = (in_valid0 && exp_rdy) || (exp_v && !out_ready0);
    end
    n_checks++;
    if (ret != 17) begin n_fail++; $display("FAIL skid0_bound: retired %0d want 17", ret); end
    @(negedge clk);
    in_valid0  = 1'b0;
    out_ready0 = 1'b0;
    n_checks++;
    if (retired_count0 !== 4'd1 || out_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL skid0_wrap: got cnt=%0d v=%0h want cnt=1 v=0", retired_count0, out_valid0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_x0_mux();
    test_async_reset();
    test_skid0_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
